adc_conv_scheduler: RTL and testbench
=====================================

ADC_CONV_SCHEDULER -- requirements
Module: adc_conv_scheduler

Interface
- REQ-001: Parameter FIFO_DEPTH, default 4; result FIFO entries, power of two, 2..16.
- REQ-002: Parameter TIMEOUT_CYCLES, default 1024; watchdog limit in clk cycles.
- REQ-003: clk  in  1  single block clock; all logic rising-edge.
- REQ-004: rst_n  in  1  reset, synchronous, active-low.
- REQ-005: sw_start_in  in  1  single-shot request pulse.
- REQ-006: timer_period_in  in  16  periodic request interval in clk cycles; 0 disables the timer.
- REQ-007: clear_in  in  1  clears sticky flags and flushes the FIFO.
- REQ-008: start_conversion_out  out  1  one-cycle start pulse to the ADC.
- REQ-009: conversion_finished_in  in  1  ADC done level from the ADC.
- REQ-010: result_in  in  16  ADC result, valid while conversion_finished_in is high.
- REQ-011: result_data_out  out  16  FIFO head.
- REQ-012: result_valid_out  out  1  FIFO non-empty.
- REQ-013: result_ready_in  in  1  consumer pop; a pop occurs when valid and ready are both high.
- REQ-014: busy_out  out  1  high in every state except IDLE.
- REQ-015: overflow_out  out  1  sticky; a result was dropped.
- REQ-016: timeout_out  out  1  sticky watchdog flag; tied 0 without the macro.

Function
- REQ-017: The FSM SHALL have states IDLE, START, WAIT and CAPTURE.
- REQ-018: Pending bits sw_pend and tmr_pend SHALL be set by their sources and cleared on grant. A repeat request while the bit is already set SHALL coalesce into it.
- REQ-019: IDLE SHALL go to START when any pending bit is set. sw_pend SHALL win a tie, and the granted bit SHALL clear in that same cycle.
- REQ-020: START SHALL last exactly 1 cycle with start_conversion_out=1, then go to WAIT.
- REQ-021: WAIT SHALL detect the rising edge of conversion_finished_in using a registered previous value. A level that is already high on WAIT entry SHALL be ignored.
- REQ-022: On the rising edge, result_in SHALL be captured and the FSM SHALL go to CAPTURE. CAPTURE SHALL push the captured value, then go to IDLE after 1 cycle.
- REQ-023: Push-to-valid latency SHALL be 1 cycle. Minimum request-to-start latency SHALL be 1 cycle (request at cycle n, start_conversion_out high at n+1).
- REQ-024: The timer counter SHALL count 0..timer_period_in-1 and set tmr_pend at wrap. The counter SHALL free-run while the FSM is busy.
- REQ-025: A change of timer_period_in SHALL restart the count at 0. A period of 0 SHALL hold the counter at 0.
- REQ-026: FIFO full with push and no pop: the push SHALL be dropped and overflow_out set.
- REQ-027: FIFO full with push and pop in the same cycle: both SHALL be accepted and there SHALL be no overflow.
- REQ-028: FIFO empty: a pop SHALL be ignored and result_data_out SHALL hold its last value.
- REQ-029: FIFO pointers SHALL wrap modulo FIFO_DEPTH. Count SHALL be log2(FIFO_DEPTH)+1 bits wide.
- REQ-030: clear_in SHALL flush the FIFO and clear overflow_out, timeout_out and both pending bits. It SHALL NOT abort an in-flight conversion.
- REQ-031: A push in the same cycle as clear_in SHALL be discarded.

Reset
- REQ-032: While rst_n=0 at a clk edge, the FSM SHALL go to IDLE and all outputs SHALL be 0: start_conversion_out, result_valid_out, busy_out, overflow_out, timeout_out, and result_data_out=16'h0000.
- REQ-033: Reset SHALL also clear the FIFO pointers, the pending bits, the timer and the edge register.
- REQ-034: Reset asserted mid-conversion SHALL abandon the conversion. A later conversion_finished_in edge SHALL be ignored unless the FSM is in WAIT.

Configuration
- REQ-035: With ADC_SCHED_TIMEOUT_EN defined, a watchdog SHALL count cycles in WAIT.
- REQ-036: On reaching TIMEOUT_CYCLES, the watchdog SHALL set timeout_out, push nothing, and return the FSM to IDLE.
- REQ-037: Without ADC_SCHED_TIMEOUT_EN, WAIT SHALL wait indefinitely and timeout_out SHALL be constant 0.

Structure
- REQ-038: Package adc_sched_pkg SHALL hold the FSM state enum, the result width constant (16) and the default FIFO_DEPTH and TIMEOUT_CYCLES values.
- REQ-039: The FIFO SHALL be a sub-module, adc_sched_fifo: synchronous, registered head, with full, empty and count outputs.

Verification
- REQ-040: sw_start_in pulse at cycle 10 -> start_conversion_out high at cycle 11 only. Finished rising edge with result_in=16'h0A5C at cycle 40 -> result_valid_out=1 and result_data_out=16'h0A5C at cycle 42.
- REQ-041: timer_period_in=100 with a 20-cycle ADC model -> exactly 10 start pulses in 1000 cycles, spaced 100 cycles apart.
- REQ-042: sw_start_in and a timer wrap in the same cycle -> one start for the sw grant, with tmr_pend still set. A second start follows after the first CAPTURE.
- REQ-043: FIFO_DEPTH=4, result_ready_in=0, 5 conversions -> 4 entries kept and overflow_out=1. A 5th push with a simultaneous pop while full -> accepted, no overflow.
- REQ-044: rst_n=0 for 1 cycle during WAIT -> all outputs 0 next cycle. A subsequent finished edge -> no push.
- REQ-045: With ADC_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=64, no finished edge -> timeout_out=1 after 64 WAIT cycles, FSM in IDLE, FIFO empty.

Source files
------------

// File: rtl/adc_sched_pkg.sv
// Shared types and defaults for the ADC conversion scheduler.
package adc_sched_pkg;

  localparam int RESULT_W               = 16;
  localparam int DEFAULT_FIFO_DEPTH     = 4;
  localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_START   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_CAPTURE = 2'd3
  } state_e;

endpackage

// File: rtl/adc_sched_fifo.sv
// Result FIFO with a registered head word; a pop while full frees the slot the
// same-cycle push writes, so full+push+pop never drops.
module adc_sched_fifo
  import adc_sched_pkg::*;
#(
  parameter int  DEPTH = DEFAULT_FIFO_DEPTH,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush_in,
  input  logic                push_in,
  input  logic [RESULT_W-1:0] push_data_in,
  input  logic                pop_in,
  output logic [RESULT_W-1:0] head_out,
  output logic                full_out,
  output logic                empty_out,
  output logic [CW-1:0]       count_out,
  output logic                drop_out
);

  logic [RESULT_W-1:0] mem_q [DEPTH];
  logic [RESULT_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]       wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]       count_q, count_d;
  logic [RESULT_W-1:0] head_q, head_d;
  logic                do_push, do_pop;

  assign empty_out = (count_q == '0);
  assign full_out  = (count_q == CW'(DEPTH));
  assign do_pop    = pop_in & ~empty_out;
  assign do_push   = push_in & (~full_out | do_pop);
  assign drop_out  = ~flush_in & push_in & full_out & ~do_pop;
  assign head_out  = head_q;
  assign count_out = count_q;

  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    head_d  = head_q;
    if (flush_in) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = push_data_in;
        wr_d        = wr_q + 1'b1;
      end
      if (do_pop) rd_d = rd_q + 1'b1;
      count_d = count_q + CW'(do_push) - CW'(do_pop);
      // When the FIFO drains to nothing the head keeps its last word.
      if ((count_q - CW'(do_pop)) == '0) begin
        if (do_push) head_d = push_data_in;
      end else begin
        head_d = mem_q[rd_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      head_q  <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      head_q  <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/adc_conv_scheduler.sv
// Arbitrates software and timer conversion requests, runs one ADC conversion at a
// time and queues results. ADC_SCHED_TIMEOUT_EN adds a WAIT-state watchdog.
module adc_conv_scheduler
  import adc_sched_pkg::*;
#(
  parameter int FIFO_DEPTH     = DEFAULT_FIFO_DEPTH,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sw_start_in,
  input  logic [15:0]         timer_period_in,
  input  logic                clear_in,
  output logic                start_conversion_out,
  input  logic                conversion_finished_in,
  input  logic [RESULT_W-1:0] result_in,
  output logic [RESULT_W-1:0] result_data_out,
  output logic                result_valid_out,
  input  logic                result_ready_in,
  output logic                busy_out,
  output logic                overflow_out,
  output logic                timeout_out,
  output state_e              state_dbg_out
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_e              state_q, state_d;
  logic                fin_prev_q, fin_rise;
  logic [RESULT_W-1:0] cap_q, cap_d;
  logic                sw_pend_q, sw_pend_d, tmr_pend_q, tmr_pend_d;
  logic                sw_req, tmr_req, grant_sw, grant_tmr;
  logic [15:0]         tmr_cnt_q, tmr_cnt_d, period_prev_q;
  logic                period_chg, tmr_wrap;
  logic                overflow_q, overflow_d;
  logic                push, wd_expire;
  logic                fifo_full, fifo_empty, fifo_drop;
  logic [CW-1:0]       fifo_count;
  logic                unused_fifo;

  assign fin_rise  = conversion_finished_in & ~fin_prev_q;
  // clear_in wins over any request that would otherwise be granted this cycle.
  assign sw_req    = ~clear_in & (sw_start_in | sw_pend_q);
  assign tmr_req   = ~clear_in & (tmr_wrap | tmr_pend_q);
  assign grant_sw  = (state_q == ST_IDLE) & sw_req;
  assign grant_tmr = (state_q == ST_IDLE) & ~sw_req & tmr_req;

  assign period_chg = (timer_period_in != period_prev_q);
  assign tmr_wrap   = (timer_period_in != 16'd0) & ~period_chg &
                      (tmr_cnt_q == timer_period_in - 16'd1);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (sw_req | tmr_req) state_d = ST_START;
      ST_START:   state_d = ST_WAIT;
      ST_WAIT:    if (fin_rise) state_d = ST_CAPTURE;
                  else if (wd_expire) state_d = ST_IDLE;
      ST_CAPTURE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    start_conversion_out = (state_q == ST_START);
    busy_out             = (state_q != ST_IDLE);
    push                 = (state_q == ST_CAPTURE) & ~clear_in;
  end

  assign state_dbg_out = state_q;

  always_comb begin
    cap_d      = ((state_q == ST_WAIT) && fin_rise) ? result_in : cap_q;
    sw_pend_d  = ~clear_in & (sw_pend_q | sw_start_in) & ~grant_sw;
    tmr_pend_d = ~clear_in & (tmr_pend_q | tmr_wrap) & ~grant_tmr;
    tmr_cnt_d  = (period_chg || tmr_wrap || timer_period_in == 16'd0) ? 16'd0
                                                                      : tmr_cnt_q + 16'd1;
    overflow_d = ~clear_in & (overflow_q | fifo_drop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fin_prev_q    <= 1'b0;
      cap_q         <= '0;
      sw_pend_q     <= 1'b0;
      tmr_pend_q    <= 1'b0;
      tmr_cnt_q     <= '0;
      period_prev_q <= '0;
      overflow_q    <= 1'b0;
    end else begin
      fin_prev_q    <= conversion_finished_in;
      cap_q         <= cap_d;
      sw_pend_q     <= sw_pend_d;
      tmr_pend_q    <= tmr_pend_d;
      tmr_cnt_q     <= tmr_cnt_d;
      period_prev_q <= timer_period_in;
      overflow_q    <= overflow_d;
    end
  end

  assign overflow_out = overflow_q;

`ifdef ADC_SCHED_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WDW-1:0] wd_cnt_q, wd_cnt_d;
  logic           timeout_q, timeout_d;

  // Expires on the TIMEOUT_CYCLES-th WAIT cycle unless the edge arrives then.
  assign wd_expire = (state_q == ST_WAIT) & ~fin_rise &
                     (wd_cnt_q == WDW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wd_cnt_d  = (state_q == ST_WAIT) ? wd_cnt_q + 1'b1 : '0;
    timeout_d = ~clear_in & (timeout_q | wd_expire);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_out = timeout_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign wd_expire      = 1'b0;
  assign timeout_out    = 1'b0;
`endif

  adc_sched_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_in     (clear_in),
    .push_in      (push),
    .push_data_in (cap_q),
    .pop_in       (result_ready_in),
    .head_out     (result_data_out),
    .full_out     (fifo_full),
    .empty_out    (fifo_empty),
    .count_out    (fifo_count),
    .drop_out     (fifo_drop)
  );

  assign result_valid_out = ~fifo_empty;
  assign unused_fifo      = ^{fifo_full, fifo_count};

endmodule

// File: tb/tb_adc_conv_scheduler.sv
// Directed bench for adc_conv_scheduler; the watchdog section follows ADC_SCHED_TIMEOUT_EN.
module tb_adc_conv_scheduler;
  import adc_sched_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, sw_start, clear, fin, ready;
  logic [15:0] period, result;
  logic        start, valid, busy, ovf, tmo;
  logic [15:0] data;
  state_e      state_dbg;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

  adc_conv_scheduler #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(64)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .sw_start_in            (sw_start),
    .timer_period_in        (period),
    .clear_in               (clear),
    .start_conversion_out   (start),
    .conversion_finished_in (fin),
    .result_in              (result),
    .result_data_out        (data),
    .result_valid_out       (valid),
    .result_ready_in        (ready),
    .busy_out               (busy),
    .overflow_out           (ovf),
    .timeout_out            (tmo),
    .state_dbg_out          (state_dbg)
  );

  // clock / global time bound
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL sim_time_limit: observed=running expected=finished");
    $fatal(1, "time limit");
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One sw-triggered conversion from IDLE; optionally pops the head during CAPTURE.
  task automatic conv(input logic [15:0] d, input bit pop_now);
    logic [15:0] e;
    sw_start = 1'b1; tick(1); sw_start = 1'b0;
    check("conv_start", start, 1'b1);
    tick(3); fin = 1'b1; result = d; tick(1);
    fin = 1'b0;
    if (pop_now) begin
      ready = 1'b1;
      e = exp_q.pop_front();
      check("conv_pop_head", data, e);
    end
    tick(1); ready = 1'b0;
  endtask

  task automatic drain_check(input int n);
    logic [15:0] e;
    ready = 1'b1;
    for (int k = 0; k < n; k++) begin
      e = exp_q.pop_front();
      check("drain_valid", valid, 1'b1);
      check("drain_data", data, e);
      tick(1);
    end
    ready = 1'b0;
    check("drain_empty", valid, 1'b0);
  endtask

  initial begin
    int n_start, last, adc_left, n_res;
    rst_n = 1'b0; sw_start = 1'b0; clear = 1'b0; fin = 1'b0; ready = 1'b0;
    period = 16'd0; result = 16'd0;
    tick(3);
    check("rst_start", start, 1'b0);
    check("rst_valid", valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    check("rst_tmo", tmo, 1'b0);
    check("rst_data", data, 16'h0000);
    check("rst_state", state_dbg, ST_IDLE);
    rst_n = 1'b1;                                  // cycle 0

    // single shot: request at 10, start at 11 only, edge at 40, valid at 42
    tick(10); sw_start = 1'b1;
    tick(1);  sw_start = 1'b0;
    check("ss_start_c11", start, 1'b1);
    check("ss_busy_c11", busy, 1'b1);
    tick(1);
    check("ss_start_c12", start, 1'b0);
    check("ss_wait_c12", state_dbg, ST_WAIT);
    tick(28); fin = 1'b1; result = 16'h0A5C;       // cycle 40
    tick(1);  result = 16'h1111;
    check("ss_valid_c41", valid, 1'b0);
    tick(1);  fin = 1'b0;
    check("ss_valid_c42", valid, 1'b1);
    check("ss_data_c42", data, 16'h0A5C);
    check("ss_idle_c42", busy, 1'b0);
    ready = 1'b1; tick(1);
    check("pop_last_valid", valid, 1'b0);
    check("pop_last_hold", data, 16'h0A5C);
    tick(1); ready = 1'b0;
    check("pop_empty_hold", data, 16'h0A5C);
    check("pop_empty_valid", valid, 1'b0);

    // finished level already high on WAIT entry is ignored
    fin = 1'b1; sw_start = 1'b1; tick(1); sw_start = 1'b0;
    tick(4);
    check("lvl_ignored", state_dbg, ST_WAIT);
    fin = 1'b0; tick(1);
    fin = 1'b1; result = 16'h5A5A; tick(1);
    fin = 1'b0; tick(1);
    check("lvl_data", data, 16'h5A5A);
    ready = 1'b1; tick(1); ready = 1'b0;

    // overflow: five pushes into four entries
    for (int i = 0; i < 5; i++) begin
      conv(16'hC000 + 16'(i), 1'b0);
      if (i < 4) exp_q.push_back(16'hC000 + 16'(i));
    end
    check("ovf_set", ovf, 1'b1);
    check("ovf_valid", valid, 1'b1);
    check("ovf_head", data, 16'hC000);
    clear = 1'b1; tick(1); clear = 1'b0;
    check("clr_ovf", ovf, 1'b0);
    check("clr_flush", valid, 1'b0);
    exp_q.delete();

    // full with push and pop together: both accepted
    for (int i = 0; i < 4; i++) begin
      conv(16'hD000 + 16'(i), 1'b0);
      exp_q.push_back(16'hD000 + 16'(i));
    end
    check("full_no_ovf_yet", ovf, 1'b0);
    conv(16'hD004, 1'b1);
    exp_q.push_back(16'hD004);
    check("full_pushpop_no_ovf", ovf, 1'b0);
    drain_check(4);

    // periodic timer: period 100, 20-cycle ADC model
    period = 16'd100; tick(101);
    check("tmr_first_start", start, 1'b1);
    n_start = 0; last = 0; adc_left = 0; n_res = 0;
    ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if (valid && ready) begin
        if (exp_q.size() == 0) check("tmr_sb_extra", valid, 1'b0);
        else begin
          check("tmr_sb_data", data, exp_q[0]);
          void'(exp_q.pop_front());
        end
      end
      if (start) begin
        n_start++;
        if (n_start > 1) check("tmr_spacing", 32'(i - last), 32'd100);
        last = i; adc_left = 20; fin = 1'b0;
      end else if (adc_left > 0) begin
        adc_left--;
        if (adc_left == 0) begin
          fin = 1'b1; result = 16'h1000 + 16'(n_res);
          exp_q.push_back(result); n_res++;
        end
      end else begin
        fin = 1'b0;
      end
      if (i == 999) period = 16'd0;
      tick(1);
    end
    check("tmr_count", n_start, 10);
    check("tmr_no_more", start, 1'b0);
    tick(3); ready = 1'b0;
    check("tmr_sb_empty", exp_q.size(), 0);
    check("tmr_fifo_empty", valid, 1'b0);

    // sw request and timer wrap together: sw first, timer stays pending
    period = 16'd50; tick(50); sw_start = 1'b1;
    tick(1); sw_start = 1'b0;
    check("tie_sw_start", start, 1'b1);
    tick(3); fin = 1'b1; result = 16'h7001; tick(1); fin = 1'b0;
    check("tie_capture", state_dbg, ST_CAPTURE);
    tick(1);
    check("tie_idle_gap", start, 1'b0);
    tick(1);
    check("tie_tmr_start", start, 1'b1);
    tick(3); fin = 1'b1; result = 16'h7002; tick(1); fin = 1'b0; tick(1);
    period = 16'd0; tick(2);
    check("tie_no_third", busy, 1'b0);
    exp_q.push_back(16'h7001); exp_q.push_back(16'h7002);
    drain_check(2);

    // repeated sw requests while busy coalesce into one
    sw_start = 1'b1; tick(1); sw_start = 1'b0; tick(1);
    sw_start = 1'b1; tick(1); sw_start = 1'b0; tick(1);
    sw_start = 1'b1; tick(1); sw_start = 1'b0;
    fin = 1'b1; result = 16'h3001; tick(1); fin = 1'b0;
    tick(1);
    check("coal_idle", busy, 1'b0);
    tick(1);
    check("coal_second_start", start, 1'b1);
    tick(3); fin = 1'b1; result = 16'h3002; tick(1); fin = 1'b0; tick(1);
    tick(1);
    check("coal_no_third", busy, 1'b0);
    exp_q.push_back(16'h3001); exp_q.push_back(16'h3002);
    drain_check(2);

    // clear mid-conversion does not abort; push with clear is discarded
    sw_start = 1'b1; tick(1); sw_start = 1'b0; tick(2);
    clear = 1'b1; tick(1); clear = 1'b0;
    check("clr_no_abort", state_dbg, ST_WAIT);
    fin = 1'b1; result = 16'h4444; tick(1); fin = 1'b0; clear = 1'b1;
    tick(1); clear = 1'b0;
    check("clr_push_discard", valid, 1'b0);
    check("clr_idle", busy, 1'b0);

    // reset during WAIT abandons the conversion
    conv(16'hBEEF, 1'b0);
    check("prerst_data", data, 16'hBEEF);
    sw_start = 1'b1; tick(1); sw_start = 1'b0; tick(2);
    rst_n = 1'b0; tick(1); rst_n = 1'b1;
    check("wrst_start", start, 1'b0);
    check("wrst_valid", valid, 1'b0);
    check("wrst_busy", busy, 1'b0);
    check("wrst_ovf", ovf, 1'b0);
    check("wrst_tmo", tmo, 1'b0);
    check("wrst_data", data, 16'h0000);
    check("wrst_state", state_dbg, ST_IDLE);
    tick(2); fin = 1'b1; result = 16'h9999; tick(3); fin = 1'b0;
    check("wrst_no_push", valid, 1'b0);
    check("wrst_no_busy", busy, 1'b0);

`ifdef ADC_SCHED_TIMEOUT_EN
    // watchdog: 64 WAIT cycles without an edge
    sw_start = 1'b1; tick(1); sw_start = 1'b0;
    tick(64);
    check("wd_busy_w64", busy, 1'b1);
    check("wd_tmo_w64", tmo, 1'b0);
    tick(1);
    check("wd_tmo_set", tmo, 1'b1);
    check("wd_idle", state_dbg, ST_IDLE);
    check("wd_fifo_empty", valid, 1'b0);
    clear = 1'b1; tick(1); clear = 1'b0;
    check("wd_tmo_clear", tmo, 1'b0);
`else
    // without the watchdog WAIT holds indefinitely
    sw_start = 1'b1; tick(1); sw_start = 1'b0;
    tick(66);
    check("nowd_tmo", tmo, 1'b0);
    check("nowd_wait", state_dbg, ST_WAIT);
    fin = 1'b1; result = 16'h6006; tick(1); fin = 1'b0; tick(1);
    check("nowd_valid", valid, 1'b1);
    check("nowd_data", data, 16'h6006);
    ready = 1'b1; tick(1); ready = 1'b0;
`endif

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
